// File: rtl/vending_pkg.sv
// Shared coin constants and dispenser state encoding
// for the vending change path.
package vending_pkg;

  localparam int NICKEL_UNITS = 1;
  localparam int DIME_UNITS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_DONE
  } disp_state_e;

endpackage

// File: rtl/coin_inventory.sv
// Saturating up/down coin counter, one per coin type.
// Simultaneous inc and dec leave the count unchanged.
module coin_inventory #(
  parameter int CNT_W = 8,
  parameter int INIT  = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nonzero_o
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_W'(INIT);
    end else if (inc_i && !dec_i) begin
      if (cnt_q != MAX) cnt_q <= cnt_q + ONE;
    end else if (dec_i && !inc_i) begin
      if (cnt_q != '0) cnt_q <= cnt_q - ONE;
    end
  end

  assign cnt_o     = cnt_q;
  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout (dimes first) driving a hopper
// one coin at a time, with inventory and shortfall report.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int AMOUNT_W    = 3,
  parameter int CNT_W       = 8,
  parameter int NICKEL_INIT = 20,
  parameter int DIME_INIT   = 10,
  parameter int PULSE_GAP   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic [AMOUNT_W-1:0] req_amount_i,
  output logic                req_ready_o,
  output logic                eject_nickel_o,
  output logic                eject_dime_o,
  input  logic                eject_ack_i,
  input  logic                refill_nickel_i,
  input  logic                refill_dime_i,
  output logic [CNT_W-1:0]    nickel_cnt_o,
  output logic [CNT_W-1:0]    dime_cnt_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                short_o,
  output logic [AMOUNT_W-1:0] short_amount_o
);

  localparam int GAP_W =
    (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
  localparam logic [AMOUNT_W-1:0] U_NICKEL =
    AMOUNT_W'(NICKEL_UNITS);
  localparam logic [AMOUNT_W-1:0] U_DIME =
    AMOUNT_W'(DIME_UNITS);

  disp_state_e         state_q, state_d;
  logic [AMOUNT_W-1:0] rem_q, rem_d;
  logic [AMOUNT_W-1:0] short_amt_q;
  logic                dime_q, dime_d;
  logic [GAP_W-1:0]    gap_q;
  logic                nickel_nz, dime_nz;
  logic                accept, ack;

  assign accept = req_valid_i && (state_q == ST_IDLE);
  assign ack    = eject_ack_i && (state_q == ST_EJECT);

  coin_inventory #(
    .CNT_W (CNT_W),
    .INIT  (NICKEL_INIT)
  ) u_nickel (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_i     (refill_nickel_i),
    .dec_i     (ack && !dime_q),
    .cnt_o     (nickel_cnt_o),
    .nonzero_o (nickel_nz)
  );

  coin_inventory #(
    .CNT_W (CNT_W),
    .INIT  (DIME_INIT)
  ) u_dime (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_i     (refill_dime_i),
    .dec_i     (ack && dime_q),
    .cnt_o     (dime_cnt_o),
    .nonzero_o (dime_nz)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dime_d  = dime_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d   = req_amount_i;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (rem_q >= U_DIME && dime_nz) begin
          dime_d  = 1'b1;
          state_d = ST_EJECT;
        end else if (rem_q >= U_NICKEL && nickel_nz) begin
          dime_d  = 1'b0;
          state_d = ST_EJECT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_EJECT: begin
        if (eject_ack_i) begin
          rem_d   = rem_q - (dime_q ? U_DIME : U_NICKEL);
          state_d = (PULSE_GAP == 0) ? ST_SELECT : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_SELECT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      dime_q      <= 1'b0;
      gap_q       <= '0;
      short_amt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dime_q  <= dime_d;
      gap_q   <= (state_q == ST_GAP) ? gap_q + GAP_ONE : '0;
      if (accept) short_amt_q <= '0;
      else if (state_q == ST_DONE) short_amt_q <= rem_q;
    end
  end

  // Strobes decode straight from state so they drop on reset.
  assign eject_dime_o   = (state_q == ST_EJECT) && dime_q;
  assign eject_nickel_o = (state_q == ST_EJECT) && !dime_q;
  assign req_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign short_o        = (state_q == ST_DONE) && (rem_q != '0);
  assign short_amount_o = short_amt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: default dispenser plus no-dime and
// no-nickel variants sharing clock and reset.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int pass = 0;
  int total = 0;

  logic       va = 0, rna = 0, rda = 0, auto_a = 1, man_a = 0;
  logic [2:0] amta = 0;
  logic       ra, ena, eda, acka, busya, donea, shorta;
  logic [7:0] nca, dca;
  logic [2:0] samta;
  assign acka = auto_a ? (ena | eda) : man_a;

  logic       vb = 0;
  logic [2:0] amtb = 0;
  logic       rb, enb, edb, ackb, busyb, doneb, shortb;
  logic [7:0] ncb, dcb;
  logic [2:0] samtb;
  assign ackb = enb | edb;

  logic       vc = 0;
  logic [2:0] amtc = 0;
  logic       rc, enc, edc, ackc, busyc, donec, shortc;
  logic [7:0] ncc, dcc;
  logic [2:0] samtc;
  assign ackc = enc | edc;

  change_dispenser dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(va), .req_amount_i(amta),
    .req_ready_o(ra),
    .eject_nickel_o(ena), .eject_dime_o(eda),
    .eject_ack_i(acka),
    .refill_nickel_i(rna), .refill_dime_i(rda),
    .nickel_cnt_o(nca), .dime_cnt_o(dca),
    .busy_o(busya), .done_o(donea),
    .short_o(shorta), .short_amount_o(samta));

  change_dispenser #(.DIME_INIT(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vb), .req_amount_i(amtb),
    .req_ready_o(rb),
    .eject_nickel_o(enb), .eject_dime_o(edb),
    .eject_ack_i(ackb),
    .refill_nickel_i(1'b0), .refill_dime_i(1'b0),
    .nickel_cnt_o(ncb), .dime_cnt_o(dcb),
    .busy_o(busyb), .done_o(doneb),
    .short_o(shortb), .short_amount_o(samtb));

  change_dispenser #(.NICKEL_INIT(0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vc), .req_amount_i(amtc),
    .req_ready_o(rc),
    .eject_nickel_o(enc), .eject_dime_o(edc),
    .eject_ack_i(ackc),
    .refill_nickel_i(1'b0), .refill_dime_i(1'b0),
    .nickel_cnt_o(ncc), .dime_cnt_o(dcc),
    .busy_o(busyc), .done_o(donec),
    .short_o(shortc), .short_amount_o(samtc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    total++;
    if ({nca, dca} !== {8'd20, 8'd10})
      $display("FAIL reset_cnt got %0d/%0d want 20/10",
               nca, dca);
    else pass++;
    total++;
    if ({ra, ena, eda, busya, donea, shorta, samta}
        !== {1'b1, 8'b0})
      $display("FAIL reset_out got r%b n%b d%b b%b dn%b s%b a%0d",
               ra, ena, eda, busya, donea, shorta, samta);
    else pass++;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_amount();
    logic st;
    st = 0;
    va = 1; amta = 0;
    tick();
    va = 0;
    st = ena | eda;
    total++;
    if (donea !== 1'b0)
      $display("FAIL zero_early got done=%b want 0", donea);
    else pass++;
    tick();
    st = st | ena | eda;
    total++;
    if ({donea, shorta, st} !== 3'b100)
      $display("FAIL zero_done got d%b s%b strobe%b want 100",
               donea, shorta, st);
    else pass++;
    tick();
  endtask

  task automatic test_greedy();
    int di, ni, dn, dcnt, ncnt;
    logic sh, rdy;
    di = -1; ni = -1; dn = -1; dcnt = 0; ncnt = 0;
    sh = 1'bx; rdy = 1'bx;
    auto_a = 1;
    va = 1; amta = 3;
    tick();
    va = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (eda) begin dcnt++; if (di < 0) di = k; end
      if (ena) begin ncnt++; if (ni < 0) ni = k; end
      if (donea && dn < 0) begin dn = k; sh = shorta; end
      if (k == 10) rdy = ra;
    end
    total++;
    if (di !== 1 || ni !== 5 || dn !== 9)
      $display("FAIL greedy_timing got d@%0d n@%0d done@%0d want 1/5/9",
               di, ni, dn);
    else pass++;
    total++;
    if (dcnt !== 1 || ncnt !== 1 || sh !== 1'b0)
      $display("FAIL greedy_coins got d%0d n%0d short%b want 1 1 0",
               dcnt, ncnt, sh);
    else pass++;
    total++;
    if ({nca, dca} !== {8'd19, 8'd9} || rdy !== 1'b1)
      $display("FAIL greedy_cnt got %0d/%0d rdy%b want 19/9 1",
               nca, dca, rdy);
    else pass++;
  endtask

  task automatic test_ack_ignored();
    auto_a = 0; man_a = 1;
    tick();
    tick();
    man_a = 0;
    tick();
    total++;
    if ({nca, dca} !== {8'd19, 8'd9} || ra !== 1'b1)
      $display("FAIL idle_ack got %0d/%0d rdy%b want 19/9 1",
               nca, dca, ra);
    else pass++;
  endtask

  task automatic test_ack_delay();
    int held, dn;
    logic [7:0] mid;
    held = 0; dn = -1; mid = 'x;
    auto_a = 0; man_a = 0;
    va = 1; amta = 2;
    tick();
    va = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      man_a = 0; rda = 0;
      if (eda) held++;
      if (k == 3) mid = dca;
      if (donea && dn < 0) dn = k;
      if (k == 5) begin man_a = 1; rda = 1; end
    end
    total++;
    if (held !== 5 || mid !== 8'd9)
      $display("FAIL ack_hold got held%0d mid%0d want 5 9",
               held, mid);
    else pass++;
    total++;
    if (dca !== 8'd9 || dn !== 9)
      $display("FAIL ack_refill got dime%0d done@%0d want 9 9",
               dca, dn);
    else pass++;
  endtask

  task automatic test_saturation();
    rna = 1;
    for (int k = 0; k < 240; k++) tick();
    rna = 0;
    tick();
    total++;
    if (nca !== 8'd255)
      $display("FAIL sat got %0d want 255", nca);
    else pass++;
    rda = 1;
    tick();
    rda = 0;
    tick();
    total++;
    if (dca !== 8'd10)
      $display("FAIL refill_dime got %0d want 10", dca);
    else pass++;
  endtask

  task automatic test_nickel_only();
    int ncnt, dcnt, dn;
    logic sh;
    ncnt = 0; dcnt = 0; dn = -1; sh = 1'bx;
    vb = 1; amtb = 4;
    tick();
    vb = 0;
    for (int k = 1; k <= 40 && dn < 0; k++) begin
      tick();
      if (enb) ncnt++;
      if (edb) dcnt++;
      if (doneb) begin dn = k; sh = shortb; end
    end
    total++;
    if (dn < 0)
      $display("FAIL nonly_timeout got no done want done");
    else pass++;
    total++;
    if (ncnt !== 4 || dcnt !== 0 || sh !== 1'b0)
      $display("FAIL nonly_coins got n%0d d%0d s%b want 4 0 0",
               ncnt, dcnt, sh);
    else pass++;
    total++;
    if (ncb !== 8'd16 || dcb !== 8'd0)
      $display("FAIL nonly_cnt got %0d/%0d want 16/0",
               ncb, dcb);
    else pass++;
  endtask

  task automatic test_shortfall();
    logic st;
    vc = 1; amtc = 1;
    tick();
    vc = 0;
    st = enc | edc;
    tick();
    st = st | enc | edc;
    total++;
    if ({donec, shortc, st} !== 3'b110)
      $display("FAIL short_pulse got d%b s%b strobe%b want 110",
               donec, shortc, st);
    else pass++;
    tick();
    total++;
    if (samtc !== 3'd1 || rc !== 1'b1)
      $display("FAIL short_amt got %0d rdy%b want 1 1",
               samtc, rc);
    else pass++;
    vc = 1; amtc = 0;
    tick();
    vc = 0;
    total++;
    if (samtc !== 3'd0)
      $display("FAIL short_clear got %0d want 0", samtc);
    else pass++;
    tick();
    total++;
    if ({donec, shortc} !== 2'b10)
      $display("FAIL short_zero got d%b s%b want 10",
               donec, shortc);
    else pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int dn, ni;
    dn = -1; ni = -1;
    auto_a = 0; man_a = 0;
    va = 1; amta = 1;
    tick();
    va = 0;
    tick();
    total++;
    if (ena !== 1'b1)
      $display("FAIL mid_strobe got %b want 1", ena);
    else pass++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ena, eda, busya, ra, nca, dca}
        !== {4'b0001, 8'd20, 8'd10})
      $display("FAIL mid_reset got n%b d%b b%b r%b %0d/%0d",
               ena, eda, busya, ra, nca, dca);
    else pass++;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (donea) dn = k;
    end
    total++;
    if (dn !== -1)
      $display("FAIL mid_nodone got done@%0d want none", dn);
    else pass++;
    auto_a = 1;
    va = 1; amta = 1;
    tick();
    va = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ena && ni < 0) ni = k;
      if (donea && dn < 0) dn = k;
    end
    total++;
    if (ni !== 1 || dn !== 5 || nca !== 8'd19)
      $display("FAIL mid_after got n@%0d done@%0d cnt%0d want 1 5 19",
               ni, dn, nca);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_zero_amount();
    test_greedy();
    test_ack_ignored();
    test_ack_delay();
    test_saturation();
    test_nickel_only();
    test_shortfall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
